// File: rtl/eu_pkg.sv
// Shared types and constants for the execution-unit issue buffer.
package eu_pkg;

    localparam int EU_PAYLOAD_W = 255;

    // Field offsets from bit 0 of the packed payload.
    localparam int EU_PID_OFF      = 0;
    localparam int EU_SHAMT_OFF    = 2;
    localparam int EU_FUNCT7_OFF   = 8;
    localparam int EU_FUNCT3_OFF   = 15;
    localparam int EU_OPCODE_OFF   = 18;
    localparam int EU_IMM_OFF      = 25;
    localparam int EU_RS2_OFF      = 89;
    localparam int EU_RS1_OFF      = 153;
    localparam int EU_INST_OFF     = 217;
    localparam int EU_RD_WE_OFF    = 249;
    localparam int EU_RD_ADDR_OFF  = 250;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic        rd_write_enable;
        logic [31:0] inst_addr;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] imm;
        logic [6:0]  op_code;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [5:0]  shamt;
        logic [1:0]  pid;
    } eu_payload_t;

endpackage

// File: rtl/eu_issue_fifo.sv
// One issue channel: show-ahead FIFO with flush and optional fall-through.
module eu_issue_fifo #(
    parameter int DEPTH       = 4,
    parameter int PAYLOAD_W   = 255,
    parameter bit FALLTHROUGH = 1'b0,
    localparam int IDX_W      = $clog2(DEPTH),
    localparam int PTR_W      = IDX_W + 1,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 wr_valid,
    input  logic [PAYLOAD_W-1:0] wr_data,
    output logic                 wr_ready,
    output logic                 rd_valid,
    output logic [PAYLOAD_W-1:0] rd_data,
    input  logic                 rd_ready,
    output logic [CNT_W-1:0]     count
);

    logic [PAYLOAD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 empty;
    logic                 full;
    logic                 bypass;
    logic                 rd_fire;
    logic                 do_wr;
    logic                 do_rd;

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0])
                && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

    assign bypass   = FALLTHROUGH && empty;
    assign wr_ready = !full;
    assign rd_valid = !flush && (bypass ? wr_valid : !empty);
    assign rd_data  = bypass ? wr_data : mem[rd_ptr[IDX_W-1:0]];
    assign rd_fire  = rd_valid && rd_ready;

    // A fall-through taken by the consumer never touches storage.
    assign do_wr = wr_valid && !full && !flush && !(bypass && rd_fire);
    assign do_rd = rd_fire && !bypass;

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr[IDX_W-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/eu_issue_buffer.sv
// Multi-channel issue buffer: WAYS independent FIFOs sharing one flush.
module eu_issue_buffer
    import eu_pkg::*;
#(
    parameter int WAYS        = 2,
    parameter int DEPTH       = 4,
    parameter int PAYLOAD_W   = EU_PAYLOAD_W,
    parameter bit FALLTHROUGH = 1'b0,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      jumpFlag_i,
    input  logic [WAYS-1:0]           valid_i,
    input  logic [WAYS*PAYLOAD_W-1:0] payload_i,
    output logic [WAYS-1:0]           ready_o,
    output logic [WAYS-1:0]           valid_o,
    output logic [WAYS*PAYLOAD_W-1:0] payload_o,
    input  logic [WAYS-1:0]           ready_i,
    output logic [WAYS*CNT_W-1:0]     count_o
);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        eu_issue_fifo #(
            .DEPTH       (DEPTH),
            .PAYLOAD_W   (PAYLOAD_W),
            .FALLTHROUGH (FALLTHROUGH)
        ) u_fifo (
            .clk      (clk),
            .reset_n  (reset_n),
            .flush    (jumpFlag_i),
            .wr_valid (valid_i[w]),
            .wr_data  (payload_i[w*PAYLOAD_W +: PAYLOAD_W]),
            .wr_ready (ready_o[w]),
            .rd_valid (valid_o[w]),
            .rd_data  (payload_o[w*PAYLOAD_W +: PAYLOAD_W]),
            .rd_ready (ready_i[w]),
            .count    (count_o[w*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_eu_issue_buffer.sv
// Scoreboard bench for eu_issue_buffer (registered and fall-through builds).
module tb_eu_issue_buffer;

    localparam int PW = 255;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          jump = 1'b0;
    logic [1:0]    vin = '0, rin = '0, rdy, vout;
    logic [2*PW-1:0] pin = '0, pout;
    logic [5:0]    cnt;
    logic [1:0]    fvin = '0, frin = '0, frdy, fvout;
    logic [2*PW-1:0] fpin = '0, fpout;
    logic [5:0]    fcnt;

    logic [PW-1:0] q0[$], q1[$], qf[$];
    logic [PW-1:0] e;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    eu_issue_buffer #(.WAYS(2), .DEPTH(4), .PAYLOAD_W(PW), .FALLTHROUGH(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .jumpFlag_i(jump),
        .valid_i(vin), .payload_i(pin), .ready_o(rdy),
        .valid_o(vout), .payload_o(pout), .ready_i(rin), .count_o(cnt)
    );

    eu_issue_buffer #(.WAYS(2), .DEPTH(4), .PAYLOAD_W(PW), .FALLTHROUGH(1'b1)) dut_ft (
        .clk(clk), .reset_n(reset_n), .jumpFlag_i(jump),
        .valid_i(fvin), .payload_i(fpin), .ready_o(frdy),
        .valid_o(fvout), .payload_o(fpout), .ready_i(frin), .count_o(fcnt)
    );

    task automatic cmp(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        checks++;
        failures++;
        $display("FAIL %s got=unexpected_read want=none", nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted read pops the scoreboard in order.
    always @(negedge clk) begin
        if (reset_n) begin
            if (vout[0] && rin[0]) begin
                if (q0.size() == 0) miss("ch0_data");
                else begin e = q0.pop_front(); cmp("ch0_data", pout[0 +: PW], e); end
            end
            if (vout[1] && rin[1]) begin
                if (q1.size() == 0) miss("ch1_data");
                else begin e = q1.pop_front(); cmp("ch1_data", pout[PW +: PW], e); end
            end
            if (fvout[0] && frin[0]) begin
                if (qf.size() == 0) miss("ft_data");
                else begin e = qf.pop_front(); cmp("ft_data", fpout[0 +: PW], e); end
            end
        end
    end

    initial begin
        #2;
        cmp("rst_count", PW'(cnt), '0);
        cmp("rst_ready", PW'(rdy), PW'(2'b11));
        cmp("rst_valid", PW'(vout), '0);
        cmp("rst_ft_ready", PW'(frdy), PW'(2'b11));
        #8 reset_n = 1'b1;

        // Fill ch0, the first write lands on the first edge after reset.
        for (int i = 0; i < 4; i++) begin
            vin = 2'b01;
            pin[0 +: PW] = PW'(32'hA1 + i);
            q0.push_back(PW'(32'hA1 + i));
            step();
        end
        cmp("full_ready", PW'(rdy[0]), '0);
        cmp("full_count0", PW'(cnt[2:0]), PW'(4));
        cmp("full_count1", PW'(cnt[5:3]), '0);
        cmp("full_valid", PW'(vout[0]), PW'(1));
        pin[0 +: PW] = PW'(8'hA5);
        step();
        cmp("drop5_count", PW'(cnt[2:0]), PW'(4));
        vin = '0;

        // Drain on consecutive cycles.
        rin = 2'b01;
        repeat (4) step();
        cmp("drain_valid", PW'(vout[0]), '0);
        cmp("drain_count", PW'(cnt[2:0]), '0);
        rin = '0;

        // Steady read+write across pointer wrap.
        for (int i = 0; i < 3; i++) begin
            vin = 2'b01;
            pin[0 +: PW] = PW'(32'hB0 + i);
            q0.push_back(PW'(32'hB0 + i));
            step();
        end
        rin = 2'b01;
        for (int k = 0; k < 10; k++) begin
            pin[0 +: PW] = PW'(32'hC0 + k);
            q0.push_back(PW'(32'hC0 + k));
            step();
            cmp("stream_count", PW'(cnt[2:0]), PW'(3));
        end
        vin = '0;
        repeat (3) step();
        rin = '0;
        cmp("stream_empty", PW'(cnt[2:0]), '0);

        // Full channel: read accepted, write refused.
        for (int i = 0; i < 4; i++) begin
            vin = 2'b01;
            pin[0 +: PW] = PW'(32'hD0 + i);
            q0.push_back(PW'(32'hD0 + i));
            step();
        end
        pin[0 +: PW] = PW'(8'hD4);
        rin = 2'b01;
        step();
        vin = '0;
        cmp("fullrw_count", PW'(cnt[2:0]), PW'(3));
        cmp("fullrw_ready", PW'(rdy[0]), PW'(1));
        repeat (3) step();
        rin = '0;
        cmp("fullrw_empty", PW'(cnt[2:0]), '0);

        // Flush with a write in flight.
        for (int i = 0; i < 2; i++) begin
            vin = 2'b11;
            pin[0 +: PW] = PW'(32'hE0 + i);
            pin[PW +: PW] = PW'(32'hF0 + i);
            q0.push_back(PW'(32'hE0 + i));
            q1.push_back(PW'(32'hF0 + i));
            step();
        end
        cmp("pre_flush_cnt", PW'(cnt), PW'({3'd2, 3'd2}));
        jump = 1'b1;
        pin[0 +: PW] = PW'(8'hE2);
        pin[PW +: PW] = PW'(8'hF2);
        #1;
        cmp("flush_valid", PW'(vout), '0);
        q0.delete();
        q1.delete();
        step();
        jump = 1'b0;
        vin = '0;
        cmp("post_flush_cnt", PW'(cnt), '0);
        cmp("post_flush_valid", PW'(vout), '0);
        vin = 2'b01;
        pin[0 +: PW] = PW'(8'h99);
        q0.push_back(PW'(8'h99));
        step();
        vin = '0;
        rin = 2'b01;
        step();
        rin = '0;
        cmp("post_flush_drain", PW'(cnt[2:0]), '0);

        // Fall-through: accepted bypass is not stored.
        fvin = 2'b01;
        frin = 2'b01;
        fpin[0 +: PW] = PW'(8'h5C);
        qf.push_back(PW'(8'h5C));
        #1;
        cmp("ft_same_cycle", fpout[0 +: PW], PW'(8'h5C));
        cmp("ft_valid", PW'(fvout[0]), PW'(1));
        step();
        fvin = '0;
        frin = '0;
        cmp("ft_bypass_cnt", PW'(fcnt[2:0]), '0);
        fvin = 2'b01;
        qf.push_back(PW'(8'h5C));
        step();
        fvin = '0;
        cmp("ft_store_cnt", PW'(fcnt[2:0]), PW'(1));
        cmp("ft_head", fpout[0 +: PW], PW'(8'h5C));
        frin = 2'b01;
        step();
        frin = '0;
        cmp("ft_drained", PW'(fcnt[2:0]), '0);

        // Async reset mid-transfer abandons entries.
        vin = 2'b10;
        pin[PW +: PW] = PW'(8'h77);
        step();
        step();
        vin = '0;
        cmp("pre_rst_cnt", PW'(cnt[5:3]), PW'(2));
        reset_n = 1'b0;
        #1;
        cmp("arst_count", PW'(cnt), '0);
        cmp("arst_valid", PW'(vout), '0);
        cmp("arst_ready", PW'(rdy), PW'(2'b11));
        #1 reset_n = 1'b1;
        step();
        cmp("after_rst_cnt", PW'(cnt), '0);

        cmp("q0_left", PW'(q0.size()), '0);
        cmp("q1_left", PW'(q1.size()), '0);
        cmp("qf_left", PW'(qf.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eu_issue_buffer.md
EU_ISSUE_BUFFER -- requirements
Module: eu_issue_buffer

Interface
REQ-001 Parameter WAYS, default 2: number of independent issue channels; legal range 1..4.
REQ-002 Parameter DEPTH, default 4: entries per channel; power of two, at least 2.
REQ-003 Parameter PAYLOAD_W, default 255: packed per-entry width (rdAddr, rdWriteEnable, instAddr, rs1, rs2, imm, opCode, funct3, funct7, shamt, pID).
REQ-004 Parameter FALLTHROUGH, default 0: when 1, an empty channel forwards its input to its output in the same cycle.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 jumpFlag_i  input  1  pipeline flush, common to all channels.
REQ-008 valid_i  input  WAYS  per-channel write request.
REQ-009 payload_i  input  WAYS*PAYLOAD_W  per-channel write data; channel w occupies bits [w*PAYLOAD_W +: PAYLOAD_W].
REQ-010 ready_o  output  WAYS  per-channel "can accept".
REQ-011 valid_o  output  WAYS  per-channel "head entry present".
REQ-012 payload_o  output  WAYS*PAYLOAD_W  per-channel head entry, same packing as payload_i.
REQ-013 ready_i  input  WAYS  per-channel consumer accept.
REQ-014 count_o  output  WAYS*$clog2(DEPTH+1)  per-channel occupancy.

Function
REQ-015 Each channel shall be a FIFO independent of the others, except for the shared flush.
REQ-016 A write shall occur when valid_i[w] && ready_o[w] && !jumpFlag_i.
REQ-017 A read shall occur when valid_o[w] && ready_i[w].
REQ-018 ready_o[w] shall equal !full[w]; a full channel shall not accept a write, even when a read occurs in the same cycle.
REQ-019 Output shall be show-ahead: valid_o[w] = !empty[w] && !jumpFlag_i, and payload_o shows the head entry combinationally.
REQ-020 With FALLTHROUGH=1 and channel empty: valid_o[w] = valid_i[w] && !jumpFlag_i, and payload_o = payload_i.
REQ-021 With FALLTHROUGH=1, a fall-through that the consumer accepts in the same cycle shall not be stored; if not accepted, the entry shall be stored as a normal write.
REQ-022 A simultaneous read and write on a non-full, non-empty channel shall leave count unchanged and advance both pointers.
REQ-023 Pointers shall be $clog2(DEPTH)+1 bits, using the wrap bit for the full/empty distinction.
- empty = pointers equal.
- full = index bits equal and wrap bits differ.
- Wrap from DEPTH-1 to 0 shall be seamless.
REQ-024 count_o[w] shall equal writes minus reads since the last reset or flush, range 0..DEPTH, registered.
REQ-025 jumpFlag_i high shall have priority over all traffic:
- On the next edge, all pointers and counts go to 0.
- Same-cycle writes and reads are discarded.
- valid_o is low during the flush cycle.
REQ-026 Latency through a non-full, empty channel shall be 1 cycle from write to valid_o (FALLTHROUGH=0) and 0 cycles (FALLTHROUGH=1).
REQ-027 payload_o is don't-care while valid_o is low; storage RAM shall not require reset.

Reset
REQ-028 While reset_n is low, asynchronously: all pointers and counts are 0, valid_o = 0, ready_o = all ones, count_o = 0.
REQ-029 Reset asserted mid-transfer shall abandon all entries; there is no partial state after deassertion.
REQ-030 The first write shall be accepted on the first rising edge after reset_n deasserts.

Structure
REQ-031 Package eu_pkg shall hold the eu_payload_t packed struct, its width constant EU_PAYLOAD_W (=255), and the field-offset constants.
REQ-032 Sub-module eu_issue_fifo (one channel: DEPTH, PAYLOAD_W, FALLTHROUGH) shall be instantiated WAYS times by a generate loop.
REQ-033 The top level shall contain only slicing and the generate loop; no cross-channel logic other than the flush fan-out.

Verification
REQ-034 WAYS=2, DEPTH=4: write 0xA1..0xA4 on ch0 with ready_i=0 -> ready_o[0]=0 after the 4th, count_o[0]=4, ch1 count 0; 5th write dropped.
REQ-035 Drain ch0 with ready_i=1 -> payload_o reads 0xA1, 0xA2, 0xA3, 0xA4 in order on consecutive cycles, then valid_o[0]=0.
REQ-036 Fill 3 entries, then read and write every cycle for 10 cycles -> count stays 3, order preserved across pointer wrap.
REQ-037 Full ch0 with read and write in the same cycle -> read occurs, write refused, count 3.
REQ-038 Two entries per channel, jumpFlag_i pulsed with valid_i=1 -> valid_o=0 that cycle, counts 0 next cycle, flushed write absent.
REQ-039 FALLTHROUGH=1, empty, valid_i=1, ready_i=1, payload 0x5C -> payload_o=0x5C same cycle, count stays 0; same stimulus with ready_i=0 -> count 1, 0x5C at the head.
